// File: rtl/servo_pkg.sv
// Shared constants and pulse-width helpers for the servo PWM generator.
package servo_pkg;

   localparam int unsigned PKG_COUNT_WIDTH     = 16;
   localparam int unsigned PKG_POSITION_WIDTH  = 8;
   localparam int unsigned PKG_PERIOD_TICKS    = 2000;
   localparam int unsigned PKG_MIN_PULSE_TICKS = 100;
   localparam int unsigned PKG_MAX_PULSE_TICKS = 200;
   localparam int unsigned PKG_CENTRE_TICKS    = (PKG_MIN_PULSE_TICKS + PKG_MAX_PULSE_TICKS) / 2;
   localparam int unsigned PKG_SLEW_STEP       = 4;

   // Position is an offset above min_p; anything past the usable span pins to max_p.
   function automatic logic [15:0] clamp_pulse(input logic [15:0] pos,
                                                input logic [15:0] min_p,
                                                input logic [15:0] max_p);
      logic [15:0] span;
      span = max_p - min_p;
      if (pos > span) begin
         clamp_pulse = max_p;
      end else begin
         clamp_pulse = min_p + pos;
      end
   endfunction

   function automatic logic [15:0] slew_pulse(input logic [15:0] cur,
                                               input logic [15:0] tgt,
                                               input logic [15:0] step);
      if (tgt > cur) begin
         slew_pulse = ((tgt - cur) <= step) ? tgt : (cur + step);
      end else begin
         slew_pulse = ((cur - tgt) <= step) ? tgt : (cur - step);
      end
   endfunction

endpackage

// File: rtl/servo_period_counter.sv
// Free-running wrap-at-MAX_COUNT counter with a terminal-count flag.
module servo_period_counter #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned MAX_COUNT = 1999
) (
   input  logic             clk_i,
   input  logic             rst_i,
   output logic [WIDTH-1:0] count_o,
   output logic             tc_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             tc_s;

   assign tc_s = (count_q == WIDTH'(MAX_COUNT));

   // Next count: wrap on terminal count, else increment.
   always_comb begin
      count_d = count_q;
      if (tc_s) begin
         count_d = {WIDTH{1'b0}};
      end else begin
         count_d = count_q + WIDTH'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= {WIDTH{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign tc_o    = tc_s;

endmodule

// File: rtl/servo_pwm_generator.sv
// 50 Hz servo PWM with a one-entry command holding register applied at period boundaries.
// Build option SERVO_SLEW_LIMIT_EN limits the pulse-width change per period to SLEW_STEP.
module servo_pwm_generator
   import servo_pkg::*;
#(
   parameter int unsigned PERIOD_TICKS    = PKG_PERIOD_TICKS,
   parameter int unsigned MIN_PULSE_TICKS = PKG_MIN_PULSE_TICKS,
   parameter int unsigned MAX_PULSE_TICKS = PKG_MAX_PULSE_TICKS,
   parameter int unsigned POSITION_WIDTH  = PKG_POSITION_WIDTH,
   parameter int unsigned COUNT_WIDTH     = PKG_COUNT_WIDTH
`ifdef SERVO_SLEW_LIMIT_EN
   ,
   parameter int unsigned SLEW_STEP       = PKG_SLEW_STEP
`endif
) (
   input  logic                      PWM_CLOCK_IN,
   input  logic                      PWM_RESET,
   input  logic [POSITION_WIDTH-1:0] POSITION_IN,
   input  logic                      POSITION_VALID,
   output logic                      POSITION_READY,
   output logic                      PWM_OUT,
   output logic                      PERIOD_DONE,
   output logic [COUNT_WIDTH-1:0]    CURRENT_PULSE
);

   localparam logic [COUNT_WIDTH-1:0] CENTRE_C = COUNT_WIDTH'((MIN_PULSE_TICKS + MAX_PULSE_TICKS) / 2);

   logic [COUNT_WIDTH-1:0] cnt_s;
   logic                   boundary_s;
   logic                   accept_s;
   logic [COUNT_WIDTH-1:0] clamp_s;

   logic                   hold_full_q, hold_full_d;
   logic [COUNT_WIDTH-1:0] hold_q, hold_d;
   logic [COUNT_WIDTH-1:0] target_q, target_d;
   logic [COUNT_WIDTH-1:0] pulse_q, pulse_d;
   logic                   pwm_q, pwm_d;
   logic                   done_q, done_d;

   servo_period_counter #(
      .WIDTH     (COUNT_WIDTH),
      .MAX_COUNT (PERIOD_TICKS - 1)
   ) u_period_counter (
      .clk_i   (PWM_CLOCK_IN),
      .rst_i   (PWM_RESET),
      .count_o (cnt_s),
      .tc_o    (boundary_s)
   );

   // Ready is purely the registered empty flag, so it never depends on VALID.
   assign accept_s = POSITION_VALID && !hold_full_q;
   assign clamp_s  = COUNT_WIDTH'(clamp_pulse(16'(POSITION_IN), 16'(MIN_PULSE_TICKS),
                                              16'(MAX_PULSE_TICKS)));

   // Holding/target transfer at the boundary, command capture, and pulse update.
   always_comb begin
      hold_full_d = hold_full_q;
      hold_d      = hold_q;
      target_d    = target_q;
      pulse_d     = pulse_q;
      if (boundary_s && hold_full_q) begin
         target_d    = hold_q;
         hold_full_d = 1'b0;
      end else begin
         target_d    = target_q;
      end
      // Ready was high, so the holding register is empty even on a boundary edge.
      if (accept_s) begin
         hold_d      = clamp_s;
         hold_full_d = 1'b1;
      end else begin
         hold_d      = hold_q;
      end
      if (boundary_s) begin
`ifdef SERVO_SLEW_LIMIT_EN
         pulse_d = COUNT_WIDTH'(slew_pulse(16'(pulse_q), 16'(target_d), 16'(SLEW_STEP)));
`else
         pulse_d = target_d;
`endif
      end else begin
         pulse_d = pulse_q;
      end
      pwm_d  = (cnt_s < pulse_q);
      done_d = boundary_s;
   end

   // State and registered outputs.
   always_ff @(posedge PWM_CLOCK_IN or posedge PWM_RESET) begin
      if (PWM_RESET) begin
         hold_full_q <= 1'b0;
         hold_q      <= {COUNT_WIDTH{1'b0}};
         target_q    <= CENTRE_C;
         pulse_q     <= CENTRE_C;
         pwm_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         hold_full_q <= hold_full_d;
         hold_q      <= hold_d;
         target_q    <= target_d;
         pulse_q     <= pulse_d;
         pwm_q       <= pwm_d;
         done_q      <= done_d;
      end
   end

   assign POSITION_READY = !hold_full_q;
   assign PWM_OUT        = pwm_q;
   assign PERIOD_DONE    = done_q;
   assign CURRENT_PULSE  = pulse_q;

endmodule

// File: tb/tb_servo_pwm_generator.sv
// Directed self-checking bench for servo_pwm_generator; every task starts and ends on a period boundary.
module tb_servo_pwm_generator;

   logic        clk;
   logic        rst;
   logic [7:0]  pos;
   logic        valid;
   logic        ready;
   logic        pwm;
   logic        done;
   logic [15:0] cur;

   int n_cmp = 0;
   int n_bad = 0;
   int hi_cnt;
   int done_cnt;
   int first_pwm;

   servo_pwm_generator dut (
      .PWM_CLOCK_IN   (clk),
      .PWM_RESET      (rst),
      .POSITION_IN    (pos),
      .POSITION_VALID (valid),
      .POSITION_READY (ready),
      .PWM_OUT        (pwm),
      .PERIOD_DONE    (done),
      .CURRENT_PULSE  (cur)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (pwm) hi_cnt++;
         if (done) done_cnt++;
      end
   endtask

   task automatic window_start();
      hi_cnt   = 0;
      done_cnt = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1; valid = 1'b0; pos = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (pwm !== 1'b0) begin n_bad++; $display("FAIL reset_pwm got %0b want 0", pwm); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b want 0", done); end
      n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %0b want 1", ready); end
      n_cmp++; if (cur !== 16'd150) begin n_bad++; $display("FAIL reset_pulse got %0d want 150", cur); end
      rst = 1'b0;
      window_start();
      step(1);
      first_pwm = pwm;
      step(1999);
      n_cmp++; if (first_pwm !== 1) begin n_bad++; $display("FAIL first_edge_pwm got %0d want 1", first_pwm); end
      n_cmp++; if (hi_cnt !== 150) begin n_bad++; $display("FAIL reset_period_high got %0d want 150", hi_cnt); end
      n_cmp++; if (done_cnt !== 1 || done !== 1'b1) begin n_bad++; $display("FAIL period_done got cnt=%0d last=%0b want 1/1", done_cnt, done); end
      window_start();
      step(2000);
      n_cmp++; if (hi_cnt !== 150 || done_cnt !== 1) begin n_bad++; $display("FAIL second_period got hi=%0d done=%0d want 150/1", hi_cnt, done_cnt); end
   endtask

   task automatic test_accept_mid();
      window_start();
      step(500);
      valid = 1'b1; pos = 8'd50;
      step(1);
      valid = 1'b0;
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL mid_ready_low got %0b want 0", ready); end
      n_cmp++; if (cur !== 16'd150) begin n_bad++; $display("FAIL mid_pulse_hold got %0d want 150", cur); end
      step(1499);
      n_cmp++; if (hi_cnt !== 150) begin n_bad++; $display("FAIL mid_period_high got %0d want 150", hi_cnt); end
      n_cmp++; if (cur !== 16'd150 || ready !== 1'b1) begin n_bad++; $display("FAIL mid_applied got pulse=%0d ready=%0b want 150/1", cur, ready); end
      window_start();
      step(2000);
      n_cmp++; if (hi_cnt !== 150) begin n_bad++; $display("FAIL mid_next_high got %0d want 150", hi_cnt); end
   endtask

   task automatic test_clamp();
      window_start();
      valid = 1'b1; pos = 8'd255;
      step(1);
      valid = 1'b0;
      step(1998);
      n_cmp++; if (cur !== 16'd150) begin n_bad++; $display("FAIL clamp_before got %0d want 150", cur); end
      step(1);
      n_cmp++; if (cur !== 16'd200) begin n_bad++; $display("FAIL clamp_pulse got %0d want 200", cur); end
      window_start();
      step(2000);
      n_cmp++; if (hi_cnt !== 200) begin n_bad++; $display("FAIL clamp_high got %0d want 200", hi_cnt); end
   endtask

   task automatic test_back_to_back();
      window_start();
      valid = 1'b1; pos = 8'd0;
      step(1);
      pos = 8'd100;
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_after_accept got %0b want 0", ready); end
      step(1998);
      n_cmp++; if (ready !== 1'b0 || cur !== 16'd200) begin n_bad++; $display("FAIL b2b_stall got ready=%0b pulse=%0d want 0/200", ready, cur); end
      step(1);
      n_cmp++; if (hi_cnt !== 200) begin n_bad++; $display("FAIL b2b_first_high got %0d want 200", hi_cnt); end
      n_cmp++; if (ready !== 1'b1 || cur !== 16'd100) begin n_bad++; $display("FAIL b2b_boundary got ready=%0b pulse=%0d want 1/100", ready, cur); end
      window_start();
      step(1);
      valid = 1'b0;
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL b2b_second_accept got %0b want 0", ready); end
      step(1999);
      n_cmp++; if (hi_cnt !== 100 || cur !== 16'd200) begin n_bad++; $display("FAIL b2b_second got hi=%0d pulse=%0d want 100/200", hi_cnt, cur); end
      window_start();
      step(2000);
      n_cmp++; if (hi_cnt !== 200) begin n_bad++; $display("FAIL b2b_third_high got %0d want 200", hi_cnt); end
   endtask

   task automatic test_boundary_accept();
      window_start();
      step(1999);
      valid = 1'b1; pos = 8'd0;
      step(1);
      valid = 1'b0;
      n_cmp++; if (cur !== 16'd200 || ready !== 1'b0) begin n_bad++; $display("FAIL bnd_accept got pulse=%0d ready=%0b want 200/0", cur, ready); end
      window_start();
      step(2000);
      n_cmp++; if (hi_cnt !== 200 || cur !== 16'd100) begin n_bad++; $display("FAIL bnd_applied got hi=%0d pulse=%0d want 200/100", hi_cnt, cur); end
   endtask

   task automatic test_reset_mid();
      window_start();
      step(10);
      valid = 1'b1; pos = 8'd100;
      step(1);
      valid = 1'b0;
      step(64);
      n_cmp++; if (pwm !== 1'b1 || ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_pre got pwm=%0b ready=%0b want 1/0", pwm, ready); end
      rst = 1'b1;
      #1;
      n_cmp++; if (pwm !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rstmid_async got pwm=%0b done=%0b want 0/0", pwm, done); end
      n_cmp++; if (cur !== 16'd150 || ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_state got pulse=%0d ready=%0b want 150/1", cur, ready); end
      rst = 1'b0;
      window_start();
      step(2000);
      n_cmp++; if (hi_cnt !== 150 || cur !== 16'd150) begin n_bad++; $display("FAIL rstmid_after got hi=%0d pulse=%0d want 150/150", hi_cnt, cur); end
   endtask

   task automatic test_slew();
      int exp_p;
      window_start();
      valid = 1'b1; pos = 8'd255;
      step(1);
      valid = 1'b0;
      step(1999);
      for (int i = 1; i <= 13; i++) begin
         exp_p = (150 + 4 * i > 200) ? 200 : 150 + 4 * i;
         n_cmp++; if (cur !== exp_p[15:0]) begin n_bad++; $display("FAIL slew_step%0d got %0d want %0d", i, cur, exp_p); end
         if (i < 13) step(2000);
      end
      step(2000);
      n_cmp++; if (cur !== 16'd200) begin n_bad++; $display("FAIL slew_settled got %0d want 200", cur); end
   endtask

   initial begin
      test_reset();
`ifdef SERVO_SLEW_LIMIT_EN
      test_slew();
`else
      test_accept_mid();
      test_clamp();
      test_back_to_back();
      test_boundary_accept();
      test_reset_mid();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
